// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared types and constants for the Flappy Bird score path
package fb_pkg;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_PLAY, S_OVER} fb_state_t;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  // Score 99 packed as {tens, ones}
  localparam logic [7:0] SCORE_SAT = {BCD_MAX, BCD_MAX};

endpackage

// File: rtl/fb_bcd_step.sv
// rtl/fb_bcd_step.sv - one-step saturating two-digit BCD incrementer with digit strobes
module fb_bcd_step
  import fb_pkg::*;
(
  input  logic       en,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  output logic [3:0] ones_next,
  output logic [3:0] tens_next,
  output logic       ones_inc,
  output logic       tens_inc,
  output logic       sat_next
);

  // Advance by one when enabled; 99 holds and emits no strobes.
  // On a ones wrap, both digit strobes fire together so the tens counter
  // takes its carry in the same cycle.
  always_comb begin
    ones_next = ones;
    tens_next = tens;
    ones_inc  = 1'b0;
    tens_inc  = 1'b0;
    if (en && ({tens, ones} != SCORE_SAT)) begin
      if (ones < BCD_MAX) begin
        ones_next = ones + 4'd1;
        ones_inc  = 1'b1;
      end else if (tens < BCD_MAX) begin
        ones_next = 4'd0;
        tens_next = tens + 4'd1;
        ones_inc  = 1'b1;
        tens_inc  = 1'b1;
      end
    end
  end

  assign sat_next = ({tens_next, ones_next} == SCORE_SAT);

endmodule

// File: rtl/fb_score_sched.sv
// rtl/fb_score_sched.sv - round sequencer and score strobe scheduler
module fb_score_sched
  import fb_pkg::*;
#(
  parameter int HOLD_TICKS = 8,
  parameter int MAX_LEVEL  = 7,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       start,
  input  logic       pipe_pass,
  input  logic       collide,
  input  logic       tick,
  output logic       ctr_clr,
  output logic       ones_inc,
  output logic       tens_inc,
  output logic [3:0] ones_bcd,
  output logic [3:0] tens_bcd,
  output logic [2:0] speed,
  output logic       playing,
  output logic       game_over,
  output logic       sat
);

  fb_state_t        state;
  fb_state_t        state_nxt;
  logic             start_q;
  logic             start_rise;
  logic [CNT_W-1:0] hold_cnt;
  logic             hold_done;
  logic             score_en;
  logic [3:0]       ones_nxt;
  logic [3:0]       tens_nxt;
  logic             ones_inc_nxt;
  logic             tens_inc_nxt;
  logic             sat_nxt;

  assign start_rise = start & ~start_q;
  assign hold_done  = (hold_cnt == CNT_W'(HOLD_TICKS));
  // A collision wins over a simultaneous pipe pass; 99 is terminal.
  assign score_en   = (state == S_PLAY) & pipe_pass & ~collide & ~sat;

  fb_bcd_step u_step (
    .en        (score_en),
    .ones      (ones_bcd),
    .tens      (tens_bcd),
    .ones_next (ones_nxt),
    .tens_next (tens_nxt),
    .ones_inc  (ones_inc_nxt),
    .tens_inc  (tens_inc_nxt),
    .sat_next  (sat_nxt)
  );

  // Round state register.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Round sequencing; early restart edges in OVER are simply dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_rise) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_PLAY;
      S_PLAY:  if (collide) state_nxt = S_OVER;
      S_OVER:  if (start_rise && hold_done) state_nxt = S_CLEAR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Start key history for rising-edge detection.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) start_q <= 1'b0;
    else      start_q <= start;
  end

  // Hold-off counter: zeroed on the way into OVER, so a tick on the
  // collision cycle never counts, then saturates at HOLD_TICKS.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      hold_cnt <= '0;
    end else if (state == S_PLAY && collide) begin
      hold_cnt <= '0;
    end else if (state == S_OVER && tick && !hold_done) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

  // Registered strobes and BCD shadow; strobes land one cycle after pipe_pass.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      ones_inc <= 1'b0;
      tens_inc <= 1'b0;
      ones_bcd <= 4'd0;
      tens_bcd <= 4'd0;
      sat      <= 1'b0;
    end else begin
      ones_inc <= ones_inc_nxt;
      tens_inc <= tens_inc_nxt;
      if (state == S_CLEAR) begin
        ones_bcd <= 4'd0;
        tens_bcd <= 4'd0;
        sat      <= 1'b0;
      end else if (score_en) begin
        ones_bcd <= ones_nxt;
        tens_bcd <= tens_nxt;
        sat      <= sat_nxt;
      end
    end
  end

  // Counters are held clear for the whole reset as well as the CLEAR cycle.
  assign ctr_clr   = ~RST | (state == S_CLEAR);
  assign playing   = (state == S_PLAY);
  assign game_over = (state == S_OVER);
  assign speed     = (tens_bcd > 4'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : tens_bcd[2:0];

endmodule

// File: tb/tb_fb_score_sched.sv
// tb/tb_fb_score_sched.sv - directed self-checking bench for fb_score_sched
module tb_fb_score_sched;

  logic       clk;
  logic       RST;
  logic       start;
  logic       pipe_pass;
  logic       collide;
  logic       tick;
  logic       ctr_clr;
  logic       ones_inc;
  logic       tens_inc;
  logic [3:0] ones_bcd;
  logic [3:0] tens_bcd;
  logic [2:0] speed;
  logic       playing;
  logic       game_over;
  logic       sat;

  int checks = 0;
  int errors = 0;

  fb_score_sched #(.HOLD_TICKS(8), .MAX_LEVEL(7), .CNT_W(4)) dut (
    .clk       (clk),
    .RST       (RST),
    .start     (start),
    .pipe_pass (pipe_pass),
    .collide   (collide),
    .tick      (tick),
    .ctr_clr   (ctr_clr),
    .ones_inc  (ones_inc),
    .tens_inc  (tens_inc),
    .ones_bcd  (ones_bcd),
    .tens_bcd  (tens_bcd),
    .speed     (speed),
    .playing   (playing),
    .game_over (game_over),
    .sat       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One isolated pipe_pass: check the strobe cycle, then that it drops.
  task automatic pass_chk(input logic eo_inc, input logic et_inc,
                          input logic [3:0] eo, input logic [3:0] et);
    pipe_pass = 1'b1;
    cyc();
    pipe_pass = 1'b0;
    chk("ones_inc", {7'd0, ones_inc}, {7'd0, eo_inc});
    chk("tens_inc", {7'd0, tens_inc}, {7'd0, et_inc});
    chk("ones_bcd", {4'd0, ones_bcd}, {4'd0, eo});
    chk("tens_bcd", {4'd0, tens_bcd}, {4'd0, et});
    cyc();
    chk("ones_inc_drop", {7'd0, ones_inc}, 8'd0);
    chk("tens_inc_drop", {7'd0, tens_inc}, 8'd0);
  endtask

  initial begin
    RST = 1'b0; start = 1'b0; pipe_pass = 1'b0; collide = 1'b0; tick = 1'b0;
    #1;
    chk("rst_ctr_clr", {7'd0, ctr_clr}, 8'd1);
    chk("rst_playing", {7'd0, playing}, 8'd0);
    chk("rst_game_over", {7'd0, game_over}, 8'd0);
    chk("rst_ones_inc", {7'd0, ones_inc}, 8'd0);
    chk("rst_score", {tens_bcd, ones_bcd}, 8'h00);
    chk("rst_sat", {7'd0, sat}, 8'd0);
    chk("rst_speed", {5'd0, speed}, 8'd0);
    cyc(); cyc();
    RST = 1'b1;
    cyc();
    chk("idle_ctr_clr", {7'd0, ctr_clr}, 8'd0);

    // IDLE ignores pipe_pass
    pipe_pass = 1'b1; cyc(); pipe_pass = 1'b0;
    chk("idle_pass_inc", {7'd0, ones_inc}, 8'd0);
    chk("idle_pass_score", {tens_bcd, ones_bcd}, 8'h00);

    // Round start: one CLEAR cycle, then PLAY
    start = 1'b1; cyc();
    chk("clear_ctr_clr", {7'd0, ctr_clr}, 8'd1);
    chk("clear_playing", {7'd0, playing}, 8'd0);
    start = 1'b0; cyc();
    chk("play_playing", {7'd0, playing}, 8'd1);
    chk("play_ctr_clr", {7'd0, ctr_clr}, 8'd0);
    chk("play_score", {tens_bcd, ones_bcd}, 8'h00);
    chk("play_no_inc", {6'd0, tens_inc, ones_inc}, 8'd0);

    // Score to 05, then collide with simultaneous pipe_pass and tick
    for (int i = 1; i <= 5; i++) pass_chk(1'b1, 1'b0, 4'(i), 4'd0);
    pipe_pass = 1'b1; collide = 1'b1; tick = 1'b1;
    cyc();
    pipe_pass = 1'b0; collide = 1'b0;
    chk("col_no_inc", {6'd0, tens_inc, ones_inc}, 8'd0);
    chk("col_score", {tens_bcd, ones_bcd}, 8'h05);
    chk("col_game_over", {7'd0, game_over}, 8'd1);
    chk("col_playing", {7'd0, playing}, 8'd0);
    // 3 counted ticks, with a pipe_pass that must not move the frozen shadow
    pipe_pass = 1'b1;
    repeat (3) cyc();
    tick = 1'b0; pipe_pass = 1'b0;
    start = 1'b1; cyc();
    chk("over3_ignored", {7'd0, game_over}, 8'd1);
    chk("over3_ctr_clr", {7'd0, ctr_clr}, 8'd0);
    chk("over_frozen", {tens_bcd, ones_bcd}, 8'h05);
    start = 1'b0; cyc();
    // 7 counted ticks: collision-cycle tick must not have counted
    tick = 1'b1; repeat (4) cyc(); tick = 1'b0;
    start = 1'b1; cyc();
    chk("over7_ignored", {7'd0, game_over}, 8'd1);
    start = 1'b0; cyc();
    tick = 1'b1; cyc(); tick = 1'b0;
    start = 1'b1; cyc();
    chk("over8_clear", {7'd0, ctr_clr}, 8'd1);
    chk("over8_game_over", {7'd0, game_over}, 8'd0);
    start = 1'b0; cyc();
    chk("restart_playing", {7'd0, playing}, 8'd1);
    chk("restart_score", {tens_bcd, ones_bcd}, 8'h00);

    // Nine ones increments, then carry into tens
    for (int i = 1; i <= 9; i++) pass_chk(1'b1, 1'b0, 4'(i), 4'd0);
    pass_chk(1'b1, 1'b1, 4'd0, 4'd1);
    chk("speed_10", {5'd0, speed}, 8'd1);

    // Back-to-back pipe_pass pulses both score
    pipe_pass = 1'b1; cyc();
    chk("b2b_first_inc", {7'd0, ones_inc}, 8'd1);
    chk("b2b_first_score", {tens_bcd, ones_bcd}, 8'h11);
    cyc(); pipe_pass = 1'b0;
    chk("b2b_second_inc", {7'd0, ones_inc}, 8'd1);
    chk("b2b_second_score", {tens_bcd, ones_bcd}, 8'h12);
    cyc();
    chk("b2b_drop", {7'd0, ones_inc}, 8'd0);

    // Run 12 -> 98 with a continuous pipe_pass, then saturate
    pipe_pass = 1'b1; repeat (86) cyc(); pipe_pass = 1'b0;
    chk("score_98", {tens_bcd, ones_bcd}, 8'h98);
    chk("sat_98", {7'd0, sat}, 8'd0);
    chk("speed_98", {5'd0, speed}, 8'd7);
    cyc();
    pass_chk(1'b1, 1'b0, 4'd9, 4'd9);
    chk("sat_99", {7'd0, sat}, 8'd1);
    chk("speed_99", {5'd0, speed}, 8'd7);
    for (int i = 0; i < 3; i++) pass_chk(1'b0, 1'b0, 4'd9, 4'd9);

    // New round clears sat, then reset lands between a pass and its strobe
    collide = 1'b1; cyc(); collide = 1'b0;
    chk("over2_game_over", {7'd0, game_over}, 8'd1);
    tick = 1'b1; repeat (8) cyc(); tick = 1'b0;
    start = 1'b1; cyc(); start = 1'b0; cyc();
    chk("round3_sat", {7'd0, sat}, 8'd0);
    chk("round3_score", {tens_bcd, ones_bcd}, 8'h00);
    pass_chk(1'b1, 1'b0, 4'd1, 4'd0);
    pipe_pass = 1'b1;
    #3;
    RST = 1'b0;
    #1;
    chk("mid_rst_ctr_clr", {7'd0, ctr_clr}, 8'd1);
    chk("mid_rst_playing", {7'd0, playing}, 8'd0);
    chk("mid_rst_score", {tens_bcd, ones_bcd}, 8'h00);
    pipe_pass = 1'b0;
    cyc();
    chk("mid_rst_no_inc", {6'd0, tens_inc, ones_inc}, 8'd0);
    chk("mid_rst_hold_clr", {7'd0, ctr_clr}, 8'd1);
    cyc();
    RST = 1'b1;
    #1;
    chk("post_rst_ctr_clr", {7'd0, ctr_clr}, 8'd0);
    chk("post_rst_playing", {7'd0, playing}, 8'd0);
    chk("post_rst_game_over", {7'd0, game_over}, 8'd0);
    pipe_pass = 1'b1; cyc(); pipe_pass = 1'b0;
    chk("post_rst_idle_inc", {7'd0, ones_inc}, 8'd0);
    chk("post_rst_score", {tens_bcd, ones_bcd}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_score_sched.md
Name: fb_score_sched

Overview:
- Game-flow controller for the Flappy Bird score path.
- Sequences the round: idle, clear, play, game-over hold.
- Converts pipe-pass events into single-cycle increment strobes for the ones and tens 7-segment score counters, with ones-to-tens carry scheduled in the same cycle.
- Keeps a BCD shadow of the score, derives a speed level from it, and clears the counters at round start.

Parameters:
HOLD_TICKS, 8, game-tick strobes in OVER before start is accepted again (>=1)
MAX_LEVEL, 7, saturation value of speed output (<=7)
CNT_W, 4, width of hold-off tick counter (2^CNT_W > HOLD_TICKS)

Ports:
clk  in  1  system clock
RST  in  1  reset, asynchronous, active-low (0 = reset)
start  in  1  start key, level, already synchronised; rising edge detected internally
pipe_pass  in  1  1-cycle pulse: pipe column has crossed the bird column
collide  in  1  level: bird overlaps pipe/ground
tick  in  1  1-cycle game-tick strobe
ctr_clr  out  1  clear pulse to ones/tens score counters
ones_inc  out  1  1-cycle increment strobe to ones-digit counter
tens_inc  out  1  1-cycle increment strobe to tens-digit counter
ones_bcd  out  4  shadow ones digit, 0-9
tens_bcd  out  4  shadow tens digit, 0-9
speed  out  3  min(tens_bcd, MAX_LEVEL)
playing  out  1  1 in PLAY
game_over  out  1  1 in OVER
sat  out  1  1 when score = 99

Behaviour:
- Reset (RST=0, async):
  - state=IDLE; ctr_clr=1 while in reset.
  - All other outputs 0; start edge register = 0.
- Edge detect: start_rise = start & ~start_q, with start_q registered each clk.
- States:
  - IDLE:
    - start_rise -> CLEAR.
    - pipe_pass, collide and tick are ignored.
  - CLEAR:
    - Exactly 1 cycle.
    - ctr_clr=1; shadow <= 00; sat <= 0.
    - Next state PLAY.
  - PLAY:
    - playing=1.
    - collide=1 -> OVER next cycle; no score that cycle, even with simultaneous pipe_pass.
    - pipe_pass & ~collide & ~sat -> score event.
  - OVER:
    - game_over=1; shadow frozen; hold counter loaded with 0 on entry.
    - Each tick increments the hold counter until it reaches HOLD_TICKS.
    - start_rise is accepted only when the hold count = HOLD_TICKS; it then goes -> CLEAR.
    - Earlier edges are discarded, not queued.
- Score event (registered outputs, 1-cycle latency from pipe_pass):
  - ones_bcd<9: ones_inc=1, tens_inc=0; ones_bcd+1.
  - ones_bcd=9, tens_bcd<9: ones_inc=1 and tens_inc=1 in the same cycle; ones_bcd<=0, tens_bcd+1.
  - Score 98 -> 99 sets sat=1.
  - At sat=1, pipe_pass produces no strobes and the shadow holds at 99 (no wrap).
- Strobes are never high for two consecutive cycles from one pipe_pass. Back-to-back pipe_pass pulses on consecutive cycles each score.
- ctr_clr is high only in CLEAR and during reset. ones_inc/tens_inc are never high with ctr_clr.
- speed is combinational from tens_bcd: clamp to MAX_LEVEL.
- Reset mid-round: immediate IDLE, shadow 00, hold counter 0; in-flight strobe is dropped.
- tick coincident with a state change to OVER does not count toward hold-off.

Decomposition:
- Shared package fb_pkg:
  - typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_PLAY, S_OVER} fb_state_t
  - localparam BCD_MAX=4'd9
  - localparam SCORE_SAT (tens=9, ones=9)
- One natural sub-module: fb_bcd_step.
  - Combinational.
  - Inputs: ones/tens BCD and an enable.
  - Outputs: next ones/tens, ones_inc, tens_inc, sat_next.
  - Reused by the future high-score register.
- The FSM and hold counter stay in fb_score_sched.

Test Plan:
- Reset then start_rise -> one cycle of ctr_clr=1, then playing=1, ones_bcd=0, tens_bcd=0, no inc strobes.
- In PLAY, 9 pipe_pass pulses -> 9 ones_inc pulses, each 1 cycle after its pipe_pass; ones_bcd=9; tens_inc never asserted.
- 10th pipe_pass -> ones_inc=1 and tens_inc=1 in the same cycle; ones_bcd=0, tens_bcd=1, speed=1.
- pipe_pass and collide in the same cycle at score 05 -> no strobes, score stays 05, game_over=1 next cycle. start_rise after 3 ticks is ignored; start_rise after 8 ticks -> CLEAR, then score 00.
- Drive score to 99 (sat=1, speed=7 with MAX_LEVEL=7), then 3 more pipe_pass -> no strobes, score stays 99.
- RST=0 asserted mid-PLAY between pipe_pass and its strobe cycle -> strobe suppressed, outputs 0, ctr_clr=1 until release, state IDLE.
